// File: rtl/dc_offset_remover_if.sv
// Sample stream bundle for the DC offset remover.
// The master drives samples in; the slave returns corrected samples and estimate.
interface dc_offset_remover_if #(
  parameter int DATA_W = 16
);
  logic              en;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [DATA_W-1:0] dc_est;
  logic              est_valid;
  logic              est_strobe;
  logic              sat_flag;

  modport master (
    output en, din, din_valid,
    input  dout, dout_valid, dc_est,
    input  est_valid, est_strobe, sat_flag
  );

  modport slave (
    input  en, din, din_valid,
    output dout, dout_valid, dc_est,
    output est_valid, est_strobe, sat_flag
  );
endinterface

// File: rtl/dc_offset_remover.sv
// Block-mean DC estimator with saturating subtraction.
// The estimate refreshes every 2^LOG2_N accepted samples.
module dc_offset_remover #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 10,
  parameter int ACC_W  = 32
) (
  input logic clk,
  input logic rst,
  dc_offset_remover_if.slave bus
);
  logic              acc_en;
  logic              last;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  din_ext;
  logic [ACC_W-1:0]  sum;
  logic [LOG2_N-1:0] cnt;
  logic [DATA_W-1:0] est_q;
  logic [DATA_W-1:0] est_next;
  logic [DATA_W:0]   diff;
  logic              ovf;
  logic [DATA_W-1:0] clamped;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              est_valid_q;
  logic              est_strobe_q;
  logic              sat_q;

  assign acc_en  = bus.en & bus.din_valid;
  assign last    = &cnt;
  assign din_ext = {{(ACC_W-DATA_W){bus.din[DATA_W-1]}}, bus.din};
  assign sum     = acc + din_ext;
  // Taking bits above LOG2_N is the floored arithmetic shift, truncated.
  assign est_next = sum[LOG2_N +: DATA_W];

  assign diff = {bus.din[DATA_W-1], bus.din}
              - {est_q[DATA_W-1], est_q};
  assign ovf  = diff[DATA_W] ^ diff[DATA_W-1];

  always_comb begin
    clamped = diff[DATA_W-1:0];
    if (ovf) begin
      clamped = diff[DATA_W]
        ? {1'b1, {(DATA_W-1){1'b0}}}
        : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      est_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      est_valid_q  <= 1'b0;
      est_strobe_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      est_strobe_q <= 1'b0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      if (acc_en) begin
        dout_q       <= clamped;
        sat_q        <= ovf;
        dout_valid_q <= 1'b1;
        cnt          <= cnt + 1'b1;
        if (last) begin
          acc          <= '0;
          est_q        <= est_next;
          est_valid_q  <= 1'b1;
          est_strobe_q <= 1'b1;
        end else begin
          acc <= sum;
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dc_est     = est_q;
  assign bus.est_valid  = est_valid_q;
  assign bus.est_strobe = est_strobe_q;
  assign bus.sat_flag   = sat_q;
endmodule

// File: tb/tb_dc_offset_remover.sv
// Directed and randomized bench for dc_offset_remover.
// A queue-based block-mean model supplies every expected value.
module tb_dc_offset_remover;
  localparam int DW = 16;
  localparam int L  = 2;
  localparam int AW = 32;
  localparam int N  = 1 << L;
  localparam int MAXV = (1 << (DW-1)) - 1;
  localparam int MINV = -(1 << (DW-1));

  logic clk = 1'b0;
  logic rst;

  dc_offset_remover_if #(.DATA_W(DW)) bus ();

  dc_offset_remover #(
    .DATA_W(DW),
    .LOG2_N(L),
    .ACC_W (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int q[$];
  int m_est;
  bit m_ev;
  int e_dout;
  bit e_dv;
  bit e_sat;
  bit e_stb;

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".dout"}, int'($signed(bus.dout)), e_dout);
    chk({tag, ".dout_valid"}, int'(bus.dout_valid), int'(e_dv));
    chk({tag, ".sat_flag"}, int'(bus.sat_flag), int'(e_sat));
    chk({tag, ".dc_est"}, int'($signed(bus.dc_est)), m_est);
    chk({tag, ".est_valid"}, int'(bus.est_valid), int'(m_ev));
    chk({tag, ".est_strobe"}, int'(bus.est_strobe), int'(e_stb));
  endtask

  function automatic int floor_div(int s, int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  task automatic model_reset();
    q.delete();
    m_est  = 0;
    m_ev   = 1'b0;
    e_dout = 0;
    e_dv   = 1'b0;
    e_sat  = 1'b0;
    e_stb  = 1'b0;
  endtask

  task automatic step(string tag, bit en, bit v, int d);
    int diff;
    int s;
    logic [31:0] dv;
    dv = d;
    bus.en        = en;
    bus.din_valid = v;
    bus.din       = dv[DW-1:0];
    e_stb = 1'b0;
    if (en && v) begin
      diff = d - m_est;
      e_sat = 1'b1;
      if (diff > MAXV) e_dout = MAXV;
      else if (diff < MINV) e_dout = MINV;
      else begin
        e_dout = diff;
        e_sat  = 1'b0;
      end
      e_dv = 1'b1;
      q.push_back(d);
      if (q.size() == N) begin
        s = q.sum();
        m_est = floor_div(s, N);
        m_ev  = 1'b1;
        e_stb = 1'b1;
        q.delete();
      end
    end else begin
      e_dv  = 1'b0;
      e_sat = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Constant input: pass-through, then zero after the first estimate.
    for (int i = 0; i < 8; i++) step("const100", 1'b1, 1'b1, 100);
    chk("const100.est_final", int'($signed(bus.dc_est)), 100);
    chk("const100.dout_final", int'($signed(bus.dout)), 0);

    // Floor rounding toward -inf.
    async_reset("rst_mid1");
    step("floor", 1'b1, 1'b1, -1);
    for (int i = 0; i < 3; i++) step("floor", 1'b1, 1'b1, -2);
    chk("floor.est", int'($signed(bus.dc_est)), -2);
    step("floor_corr", 1'b1, 1'b1, -2);
    chk("floor_corr.dout", int'($signed(bus.dout)), 0);

    // Saturation in both directions.
    for (int i = 0; i < 3; i++) step("sat_lo", 1'b1, 1'b1, -100);
    for (int i = 0; i < 4; i++) step("sat_lo", 1'b1, 1'b1, -100);
    chk("sat_lo.est", int'($signed(bus.dc_est)), -100);
    step("sat_pos", 1'b1, 1'b1, 32767);
    chk("sat_pos.flag", int'(bus.sat_flag), 1);
    for (int i = 0; i < 3; i++) step("sat_hi", 1'b1, 1'b1, 100);
    for (int i = 0; i < 4; i++) step("sat_hi", 1'b1, 1'b1, 100);
    step("sat_neg", 1'b1, 1'b1, -32768);
    chk("sat_neg.dout", int'($signed(bus.dout)), -32768);
    step("nosat", 1'b1, 1'b1, 0);
    chk("nosat.dout", int'($signed(bus.dout)), -100);

    // Gaps and enable low do not break the block.
    async_reset("rst_mid2");
    step("gap", 1'b1, 1'b1, 8);
    step("gap", 1'b1, 1'b0, 8);
    step("gap", 1'b1, 1'b1, 8);
    step("gap", 1'b0, 1'b1, 8);
    step("gap", 1'b0, 1'b1, 8);
    step("gap", 1'b0, 1'b0, 8);
    step("gap", 1'b1, 1'b1, 8);
    step("gap", 1'b1, 1'b0, 8);
    step("gap", 1'b1, 1'b1, 8);
    chk("gap.est", int'($signed(bus.dc_est)), 8);

    // Reset mid-block discards the partial sum.
    step("rmb", 1'b1, 1'b1, 40);
    step("rmb", 1'b1, 1'b1, 40);
    async_reset("rst_mid3");
    for (int i = 0; i < 3; i++) step("rmb_post", 1'b1, 1'b1, 8);
    chk("rmb.est_valid_pre", int'(bus.est_valid), 0);
    step("rmb_post", 1'b1, 1'b1, 8);
    chk("rmb.est", int'($signed(bus.dc_est)), 8);

    // Randomized traffic with mixed enable/valid and extreme samples.
    for (int i = 0; i < 300; i++) begin
      int d;
      bit en;
      bit v;
      en = ($urandom_range(0, 7) != 0);
      v  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        d = int'($urandom_range(0, 65535)) - 32768;
      else
        d = int'($urandom_range(0, 400)) - 200 + 1000;
      step("rand", en, v, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
